// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: flag packing and skid-buffer states.
package alu_pkg;

    // Flag vector width and bit positions: {carry, zero, parity, sign, overflow}
    localparam int unsigned FLAG_W      = 5;
    localparam int unsigned FLAG_CARRY  = 4;
    localparam int unsigned FLAG_ZERO   = 3;
    localparam int unsigned FLAG_PARITY = 2;
    localparam int unsigned FLAG_SIGN   = 1;
    localparam int unsigned FLAG_OVF    = 0;

    // Occupancy of the 2-entry skid buffer
    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } skid_state_t;

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry skid buffer with valid/ready on both sides.
// The head register drives the output; the skid register catches the
// second entry so that in_ready depends only on registered state.
module alu_skid_buf
    import alu_pkg::*;
#(
    parameter int unsigned W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state;
    skid_state_t  state_nxt;
    logic [W-1:0] head;
    logic [W-1:0] skid;
    logic         push;
    logic         pop;
    logic         ld_head_in;
    logic         ld_head_skid;
    logic         ld_skid;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = head;

    // State, head and skid registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            state <= state_nxt;
            if (ld_head_in) begin
                head <= in_data;
            end else if (ld_head_skid) begin
                head <= skid;
            end
            if (ld_skid) begin
                skid <= in_data;
            end
        end
    end

    // Next-state and register load selection
    always_comb begin
        state_nxt    = state;
        ld_head_in   = 1'b0;
        ld_head_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    ld_head_in = 1'b1;
                    state_nxt  = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    ld_head_in = 1'b1;
                end else if (push) begin
                    ld_skid   = 1'b1;
                    state_nxt = TWO;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    ld_head_skid = 1'b1;
                    state_nxt    = ONE;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind full_adder: skid-buffers sum and flags,
// keeps a sticky OR of accepted flags and a saturating accept counter.
// Optional macro ALU_RESULT_FLAG_CHECK_EN enables the zero/parity flag
// consistency check driving chk_err; otherwise chk_err is tied 0.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [FLAG_W-1:0] in_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [FLAG_W-1:0] out_flags,
    output logic [FLAG_W-1:0] sticky_flags,
    input  logic              clr_sticky,
    output logic [CNT_W-1:0]  acc_count,
    output logic              chk_err
);

    localparam int unsigned PW = DATA_W + FLAG_W;

    logic [PW-1:0]    buf_out;
    logic             push;
    logic [CNT_W-1:0] cnt_base;

    assign push = in_valid & in_ready;

    alu_skid_buf #(
        .W(PW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({in_data, in_flags}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (buf_out)
    );

    assign out_data  = buf_out[PW-1:FLAG_W];
    assign out_flags = buf_out[FLAG_W-1:0];

    // A clear and a push in the same cycle: the clear applies first, the push still counts
    assign cnt_base = clr_sticky ? '0 : acc_count;

    // Sticky flag accumulation and saturating accept counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_flags <= '0;
            acc_count    <= '0;
        end else begin
            sticky_flags <= (clr_sticky ? '0 : sticky_flags) | (push ? in_flags : '0);
            if (push && (cnt_base != '1)) begin
                acc_count <= cnt_base + CNT_W'(1);
            end else begin
                acc_count <= cnt_base;
            end
        end
    end

`ifdef ALU_RESULT_FLAG_CHECK_EN
    logic chk_q;
    logic flag_bad;

    assign flag_bad = ((in_data == '0) != in_flags[FLAG_ZERO]) ||
                      ((^in_data) != in_flags[FLAG_PARITY]);

    // Sticky zero/parity mismatch; a mismatch in the clear cycle still sets it
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q <= 1'b0;
        end else begin
            chk_q <= (clr_sticky ? 1'b0 : chk_q) | (push & flag_bad);
        end
    end

    assign chk_err = chk_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed vector table,
// hand-written flag-check sequence and randomized traffic against a
// queue-based reference model. A second instance uses CNT_W=2.
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic [4:0] in_flags;
    logic       out_ready;
    logic       clr_sticky;

    logic       in_ready, out_valid, chk_err;
    logic [7:0] out_data, acc_count;
    logic [4:0] out_flags, sticky_flags;

    logic       s_in_ready, s_out_valid, s_chk_err;
    logic [7:0] s_out_data;
    logic [1:0] s_acc_count;
    logic [4:0] s_out_flags, s_sticky_flags;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [12:0] q[$];
    logic [4:0]  m_sticky;
    int          m_cnt;
    int          m_sat;
    bit          m_chk;

    always #5 clk = ~clk;

    alu_result_stage #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_flags(in_flags), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
        .sticky_flags(sticky_flags), .clr_sticky(clr_sticky),
        .acc_count(acc_count), .chk_err(chk_err)
    );

    alu_result_stage #(.DATA_W(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_flags(in_flags), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_data(s_out_data), .out_flags(s_out_flags),
        .sticky_flags(s_sticky_flags), .clr_sticky(clr_sticky),
        .acc_count(s_acc_count), .chk_err(s_chk_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit flags_bad(input logic [7:0] d, input logic [4:0] f);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        return ((d == 8'h00) != f[3]) || ((ones % 2) != f[2]);
    endfunction

    function automatic logic [4:0] good_flags(input logic [7:0] d, input logic [4:0] f);
        logic [4:0] g = f;
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        g[3] = (d == 8'h00);
        g[2] = (ones % 2);
        return g;
    endfunction

    // Advance the reference model by one clock with the currently applied inputs
    task automatic model_step();
        bit push, pop;
        if (rst) begin
            q.delete();
            m_sticky = '0;
            m_cnt = 0;
            m_sat = 0;
            m_chk = 0;
            return;
        end
        push = in_valid && (q.size() < 2);
        pop  = (q.size() > 0) && out_ready;
        m_sticky = (clr_sticky ? 5'b0 : m_sticky) | (push ? in_flags : 5'b0);
        if (clr_sticky) begin
            m_cnt = 0;
            m_sat = 0;
            m_chk = 0;
        end
        if (push && m_cnt < 255) m_cnt++;
        if (push && m_sat < 3) m_sat++;
`ifdef ALU_RESULT_FLAG_CHECK_EN
        if (push && flags_bad(in_data, in_flags)) m_chk = 1;
`endif
        if (pop) void'(q.pop_front());
        if (push) q.push_back({in_data, in_flags});
    endtask

    task automatic compare_model();
        check("in_ready", in_ready, q.size() < 2);
        check("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            check("out_data", out_data, q[0][12:5]);
            check("out_flags", out_flags, q[0][4:0]);
        end
        check("sticky", sticky_flags, m_sticky);
        check("acc_count", acc_count, m_cnt);
        check("sat_count", s_acc_count, m_sat);
        check("chk_err", chk_err, m_chk);
    endtask

    // Apply one cycle of inputs, clock it through DUT and model, sample at negedge
    task automatic cycle(input logic r, input logic iv, input logic [7:0] d,
                         input logic [4:0] f, input logic ordy, input logic clr);
        rst = r; in_valid = iv; in_data = d; in_flags = f;
        out_ready = ordy; clr_sticky = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic [4:0] f;
        logic       ordy;
        logic       clr;
        logic       eov;
        logic [7:0] ed;
        logic [4:0] ef;
        logic       eir;
        int         ecnt;
        logic [4:0] est;
        int         esat;
    } vec_t;

    vec_t vt[11];

    initial begin
        //            iv  d      f         ordy clr  eov ed     ef        eir cnt sticky    sat
        vt[0]  = '{1, 8'h04, 5'b00100, 1, 0,   1, 8'h04, 5'b00100, 1,  1, 5'b00100, 1};
        vt[1]  = '{0, 8'h00, 5'b00000, 1, 0,   0, 8'h00, 5'b00000, 1,  1, 5'b00100, 1};
        vt[2]  = '{1, 8'h10, 5'b10000, 0, 0,   1, 8'h10, 5'b10000, 1,  2, 5'b10100, 2};
        vt[3]  = '{1, 8'h0B, 5'b00010, 0, 0,   1, 8'h10, 5'b10000, 0,  3, 5'b10110, 3};
        vt[4]  = '{1, 8'hFF, 5'b00001, 0, 0,   1, 8'h10, 5'b10000, 0,  3, 5'b10110, 3};
        vt[5]  = '{0, 8'h00, 5'b00000, 1, 0,   1, 8'h0B, 5'b00010, 1,  3, 5'b10110, 3};
        vt[6]  = '{0, 8'h00, 5'b00000, 1, 0,   0, 8'h00, 5'b00000, 1,  3, 5'b10110, 3};
        vt[7]  = '{1, 8'h0E, 5'b00000, 0, 0,   1, 8'h0E, 5'b00000, 1,  4, 5'b10110, 3};
        vt[8]  = '{1, 8'h00, 5'b01000, 1, 0,   1, 8'h00, 5'b01000, 1,  5, 5'b11110, 3};
        vt[9]  = '{1, 8'h10, 5'b10000, 1, 1,   1, 8'h10, 5'b10000, 1,  1, 5'b10000, 1};
        vt[10] = '{0, 8'h00, 5'b00000, 1, 0,   0, 8'h00, 5'b00000, 1,  1, 5'b10000, 1};

        // reset and reset-state checks
        cycle(1, 0, 8'h00, 5'b0, 0, 0);
        cycle(1, 0, 8'h00, 5'b0, 0, 0);
        cycle(0, 0, 8'h00, 5'b0, 0, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_flags", out_flags, 0);
        check("rst_sticky", sticky_flags, 0);
        check("rst_count", acc_count, 0);
        check("rst_chk", chk_err, 0);

        // directed vector table
        for (int i = 0; i < 11; i++) begin
            cycle(0, vt[i].iv, vt[i].d, vt[i].f, vt[i].ordy, vt[i].clr);
            check($sformatf("v%0d_out_valid", i), out_valid, vt[i].eov);
            if (vt[i].eov) begin
                check($sformatf("v%0d_out_data", i), out_data, vt[i].ed);
                check($sformatf("v%0d_out_flags", i), out_flags, vt[i].ef);
            end
            check($sformatf("v%0d_in_ready", i), in_ready, vt[i].eir);
            check($sformatf("v%0d_count", i), acc_count, vt[i].ecnt);
            check($sformatf("v%0d_sticky", i), sticky_flags, vt[i].est);
            check($sformatf("v%0d_sat", i), s_acc_count, vt[i].esat);
            check($sformatf("v%0d_chk", i), chk_err, m_chk);
        end

        // hold-stable under backpressure: head must not change while stalled
        cycle(0, 1, 8'hA5, 5'b00000, 0, 1);
        cycle(0, 1, 8'h3C, 5'b00000, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 8'h77, 5'b11111, 0, 0);
            check("hold_data", out_data, 8'hA5);
            check("hold_in_ready", in_ready, 0);
        end
        cycle(0, 0, 8'h00, 5'b0, 1, 0);
        check("drain1", out_data, 8'h3C);
        cycle(0, 0, 8'h00, 5'b0, 1, 0);
        check("drain_empty", out_valid, 0);

        // flag-check sequence: zero result reported with zero flag clear
        cycle(0, 0, 8'h00, 5'b0, 1, 1);
        check("chk_cleared", chk_err, 0);
        cycle(0, 1, 8'h00, 5'b00000, 1, 0);
`ifdef ALU_RESULT_FLAG_CHECK_EN
        check("chk_set", chk_err, 1);
`else
        check("chk_tied", chk_err, 0);
`endif
        cycle(0, 1, 8'h01, 5'b00100, 1, 0);
        cycle(0, 0, 8'h00, 5'b0, 1, 0);
        check("chk_held", chk_err, m_chk);
        cycle(0, 0, 8'h00, 5'b0, 1, 1);
        check("chk_clr", chk_err, 0);
        // mismatch in the clear cycle is retained
        cycle(0, 1, 8'h03, 5'b00100, 1, 1);
        check("chk_clr_same", chk_err, m_chk);
        compare_model();

        // randomized traffic including occasional clears and mid-run resets
        for (int n = 0; n < 400; n++) begin
            logic [7:0] d;
            logic [4:0] f;
            d = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            f = 5'($urandom);
            if ($urandom_range(0, 1) == 0) f = good_flags(d, f);
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, d, f,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
            compare_model();
        end

        // long push burst with a draining consumer drives both counters into saturation
        for (int n = 0; n < 300; n++) begin
            cycle(0, 1, 8'(n), good_flags(8'(n), 5'b0), 1, 0);
        end
        compare_model();
        check("sat_full", acc_count, 8'hFF);
        check("sat_small", s_acc_count, 2'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Registered output stage directly downstream of full_adder. It captures the 8-bit sum and the five status flags into a 2-entry skid buffer with valid/ready handshakes on both sides. It also keeps a sticky OR of flags and a saturating count of accepted results for the ALU control path. It decouples the combinational reversible-gate adder from the consumer, such as the writeback or display logic.

Parameters:
DATA_W, 8, width of result word (matches full_adder out)
CNT_W, 8, width of accepted-result counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  adder result/flags valid this cycle
in_ready  output  1  stage can accept
in_data  input  DATA_W  adder out
in_flags  input  5  {carry, zero, parity, sign, overflow}, bit4..bit0
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head
out_data  output  DATA_W  head result
out_flags  output  5  head flags, same packing
sticky_flags  output  5  OR of all accepted flags since last clear
clr_sticky  input  1  clear sticky_flags and acc_count
acc_count  output  CNT_W  accepted results, saturating
chk_err  output  1  flag-consistency error, sticky (FLAG_CHECK_EN only; tied 0 otherwise)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). No other clock or reset domains.
- Reset: state=EMPTY, out_valid=0, out_data=0, out_flags=0, sticky_flags=0, acc_count=0, chk_err=0. in_ready=1 in the cycle after reset.
- Storage: head register (drives out_*) and skid register.
- States: EMPTY, ONE, TWO.
- in_ready = (state != TWO); it is a function of registered state only.
- push = in_valid & in_ready; pop = out_valid & out_ready. out_valid = (state != EMPTY).
- EMPTY: push loads head, go to ONE.
- ONE, push only: load skid, go to TWO.
- ONE, pop only: go to EMPTY.
- ONE, push and pop: load head with the input, stay in ONE.
- TWO, pop: skid moves to head, go to ONE. There is no push in TWO because in_ready=0.
- Latency: input to out_valid is 1 cycle when empty.
- Ordering is strict FIFO. No entry is dropped or duplicated.
- out_data/out_flags hold stable while out_valid & !out_ready.
- Data is captured verbatim; this stage does no arithmetic on it.
- sticky_flags next = (clr_sticky ? 0 : sticky_flags) | (push ? in_flags : 0). A push in the clear cycle is retained.
- acc_count next = (clr_sticky ? 0 : acc_count) + push, saturating at 2^CNT_W-1 (no wrap).
- rst mid-operation discards both entries. Handshake outputs are valid the next cycle.

Optional Feature:
- Macro: ALU_RESULT_FLAG_CHECK_EN.
- Defined: on each push, recompute zero = (in_data==0) and parity = ^in_data (1 = odd number of ones).
  - Mismatch with in_flags[3] or in_flags[2] sets chk_err.
  - chk_err is cleared only by rst or clr_sticky; a same-cycle mismatch with clr_sticky still sets it.
- Undefined: chk_err tied 0, no check logic.

Decomposition:
- Package alu_pkg holds:
  - FLAG_W=5
  - Flag index constants FLAG_CARRY=4, FLAG_ZERO=3, FLAG_PARITY=2, FLAG_SIGN=1, FLAG_OVF=0
  - Skid-state enum {EMPTY, ONE, TWO}
- One natural sub-module: alu_skid_buf, the 2-entry storage plus FSM, parameterised on payload width DATA_W+FLAG_W.
- Sticky, counter and check logic stay in the top.

Test Plan:
- Single push, 3+1: data=0x04, flags=5'b00100, out_ready=1 -> out_valid the next cycle with 0x04/00100, acc_count=1, sticky=00100.
- Backpressure: out_ready=0, push 0x10/10000 then 0x0B/00010 -> in_ready=0 after the second push, third push stalls; release out_ready -> 0x10 then 0x0B in order.
- Simultaneous push/pop in ONE: head 0x0E, push 0x00/01000 with out_ready=1 -> head=0x00 next cycle, state remains ONE, count +1.
- clr_sticky with same-cycle push of 0x10/10000 -> sticky=10000, acc_count=1.
- Saturation: CNT_W=2, five pushes -> acc_count stays 3.
- ALU_RESULT_FLAG_CHECK_EN: push 0x00 with zero=0 -> chk_err=1 and held; clr_sticky -> 0. With the macro undefined -> chk_err stays 0.
